fm_wm_read_server: RTL
======================

# fm_wm_read_server

Memory-side responder for the transformation datapath. It accepts row/column read requests for the weight and feature matrices, translates them into addresses on a single-port synchronous memory, and returns the read vectors in order through a valid/ready response channel with a bounded output buffer. It sits between the transformation control FSM/datapath (requester) and the combined weight/feature memory.

## Interface
- FEATURE_ROWS, 6, number of feature-matrix rows
- WEIGHT_COLS, 3, number of weight-matrix columns
- VEC_WIDTH, 480, bits per memory word (one weight column or one feature row)
- RSP_DEPTH, 4, response buffer entries; power of two, minimum 2
- INDEX_WIDTH, $clog2(FEATURE_ROWS), request index width (FEATURE_ROWS ≥ WEIGHT_COLS)
- ADDR_WIDTH, $clog2(FEATURE_ROWS+WEIGHT_COLS), memory address width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid && ready
- req_sel  in  1  0 = weight column, 1 = feature row (same polarity as read_feature_or_weight)
- req_index  in  INDEX_WIDTH  column/row number
- mem_read_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_rdata  in  VEC_WIDTH  read data, valid exactly 1 cycle after mem_read_en
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response when valid && ready
- rsp_data  out  VEC_WIDTH  read vector, 0 on error
- rsp_error  out  1  request index out of range
- busy  out  1  any request in pipeline or buffer

## Operation
- Address map: weight col i → addr i; feature row j → addr WEIGHT_COLS + j.
- Range check: weight index ≥ WEIGHT_COLS or feature index ≥ FEATURE_ROWS → error request; no mem_read_en; travels the same pipeline so ordering is preserved; response rsp_error=1, rsp_data=0.
- Pipeline: S1 registered request (valid, addr, err) → S2 memory wait (valid, err) → push into RSP_DEPTH FIFO; S2 error entries push data 0.
- Credit control: outstanding = S1 valid + S2 valid + FIFO count. req_ready = (outstanding < RSP_DEPTH). Pop in the same cycle does not free credit until the next cycle; this keeps req_ready a registered-state function with no combinational rsp_ready→req_ready path.
- FIFO never overflows by construction; overflow is an assertion failure.
- rsp_valid = FIFO not empty; rsp_data/rsp_error from FIFO head.
- busy = outstanding != 0.
- Reset (any time): S1/S2 valids cleared, FIFO emptied, in-flight memory data discarded, no response emitted for pre-reset requests.

## Timing
- Reset values: req_ready 1, mem_read_en 0, mem_addr 0, rsp_valid 0, rsp_data 0, rsp_error 0, busy 0.
- Request accepted at edge N → mem_read_en=1, mem_addr valid during cycle N+1 → mem_rdata sampled at edge N+2 into FIFO → rsp_valid=1 in cycle N+2 after that edge (3-edge latency, accept to FIFO write).
- Throughput: one request per cycle sustained while rsp_ready=1 and RSP_DEPTH ≥ 4; RSP_DEPTH=2 limits to one per 2 cycles.
- Push and pop in the same cycle with FIFO full: both occur, count unchanged.
- rsp_valid/rsp_data hold stable while rsp_ready=0.

## Structure
- gcn_pkg: req_sel_t enum (SEL_WEIGHT=1'b0, SEL_FEATURE=1'b1); shared FEATURE_ROWS/WEIGHT_COLS defaults.
- Sub-module: sync_fifo (parameterised WIDTH=VEC_WIDTH+1, DEPTH=RSP_DEPTH, count output), reusable elsewhere.
- Top: address/range logic, S1/S2 registers, credit counter.

## Test plan
- Weight idx 2 at edge 0 → mem_addr 2 with mem_read_en in cycle 1; memory returns 0xA5.. → rsp_data 0xA5.., rsp_error 0, rsp_valid in cycle 2.
- Feature idx 0 then idx 5 back-to-back → mem_addr 3 then 8 in consecutive cycles; responses in same order.
- Feature idx 6, weight idx 3 → no mem_read_en; two responses rsp_error 1, data 0, ordered between surrounding valid requests.
- rsp_ready=0, 10 requests offered → exactly 4 accepted, req_ready 0 thereafter; release rsp_ready → 4 responses then remaining accepted in order.
- 9 streamed requests (all weights, all features) with rsp_ready=1 → one accept per cycle, 9 responses, no bubbles, busy falls 3 cycles after last accept.
- Reset asserted with 3 requests outstanding → next cycle rsp_valid 0, busy 0, req_ready 1; no stale responses after release.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared types and default dimensions for the GCN transformation datapath.
// The request selector polarity matches read_feature_or_weight.
package gcn_pkg;

    typedef enum logic {
        SEL_WEIGHT  = 1'b0,
        SEL_FEATURE = 1'b1
    } req_sel_t;

    localparam int DEF_FEATURE_ROWS = 6;
    localparam int DEF_WEIGHT_COLS  = 3;
    localparam int DEF_VEC_WIDTH    = 480;
    localparam int DEF_RSP_DEPTH    = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push while full is allowed only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~w_full | w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is not reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_push && w_full && !w_do_pop));

endmodule

// File: rtl/fm_wm_read_server.sv
// Weight/feature read server: maps row/column requests onto the shared memory
// and returns vectors in order through a credit-limited response FIFO.
module fm_wm_read_server
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS = DEF_FEATURE_ROWS,
    parameter int WEIGHT_COLS  = DEF_WEIGHT_COLS,
    parameter int VEC_WIDTH    = DEF_VEC_WIDTH,
    parameter int RSP_DEPTH    = DEF_RSP_DEPTH,
    parameter int INDEX_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int ADDR_WIDTH   = $clog2(FEATURE_ROWS + WEIGHT_COLS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_sel,
    input  logic [INDEX_WIDTH-1:0] req_index,
    output logic                   mem_read_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [VEC_WIDTH-1:0]   mem_rdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [VEC_WIDTH-1:0]   rsp_data,
    output logic                   rsp_error,
    output logic                   busy
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int OUT_W = CNT_W + 1;

    req_sel_t              w_sel;
    logic                  w_accept;
    logic                  w_req_err;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [OUT_W-1:0]      w_outstanding;
    logic [CNT_W-1:0]      w_fifo_count;
    logic                  w_fifo_empty;
    logic [VEC_WIDTH:0]    w_push_data;
    logic [VEC_WIDTH:0]    w_head;

    logic                  r_s1_valid;
    logic                  r_s1_err;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic                  r_s2_valid;
    logic                  r_s2_err;

    assign w_sel = req_sel_t'(req_sel);

    always_comb begin
        w_req_err  = 1'b0;
        w_req_addr = '0;
        if (w_sel == SEL_FEATURE) begin
            w_req_err  = (int'(req_index) >= FEATURE_ROWS);
            w_req_addr = ADDR_WIDTH'(WEIGHT_COLS + int'(req_index));
        end else begin
            w_req_err  = (int'(req_index) >= WEIGHT_COLS);
            w_req_addr = ADDR_WIDTH'(req_index);
        end
        if (w_req_err) w_req_addr = '0;
    end

    // Credit counts only registered state, so a pop frees its slot one cycle later
    // and there is no combinational path from rsp_ready to req_ready.
    assign w_outstanding = OUT_W'(r_s1_valid) + OUT_W'(r_s2_valid) + OUT_W'(w_fifo_count);
    assign req_ready     = (w_outstanding < OUT_W'(RSP_DEPTH));
    assign busy          = (w_outstanding != '0);
    assign w_accept      = req_valid & req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_addr  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= r_s1_err;
            if (w_accept) begin
                r_s1_err  <= w_req_err;
                r_s1_addr <= w_req_addr;
            end
        end
    end

    assign mem_read_en = r_s1_valid & ~r_s1_err;
    assign mem_addr    = r_s1_addr;

    assign w_push_data = {r_s2_err, r_s2_err ? {VEC_WIDTH{1'b0}} : mem_rdata};

    sync_fifo #(
        .WIDTH (VEC_WIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_s2_valid),
        .i_push_data (w_push_data),
        .i_pop       (rsp_valid & rsp_ready),
        .o_pop_data  (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Head data is masked while empty so the unreset storage never reaches the port.
    assign rsp_valid = ~w_fifo_empty;
    assign rsp_data  = rsp_valid ? w_head[VEC_WIDTH-1:0] : '0;
    assign rsp_error = rsp_valid & w_head[VEC_WIDTH];

endmodule
